// File: rtl/opendap_dp_pkg.sv
// opendap_dp_pkg: shared DP field widths, AP address layout and scheduler state encoding.
package opendap_dp_pkg;
  localparam int APSEL_W = 8;
  localparam int BANK_W = 4;
  localparam int AP_A_LSB = 2;
  localparam int AP_BANK_LSB = 4;
  localparam int AP_APSEL_LSB = AP_BANK_LSB + BANK_W;
  typedef enum logic {SCHED_IDLE = 1'b0, SCHED_BUSY = 1'b1} sched_state_e;
endpackage

// File: rtl/opendap_ap_access_scheduler.sv
// opendap_ap_access_scheduler: serialises DP AP accesses onto a req/ack bus with posted reads,
// abort/timeout cancellation and sticky-error reporting.
module opendap_ap_access_scheduler
  import opendap_dp_pkg::*;
#(
  parameter int W_APSEL = APSEL_W,
  parameter int W_BANK = BANK_W,
  parameter int W_TIMEOUT = 8
) (
  input  logic                      swclk,
  input  logic                      rst_n,
  input  logic                      dp_ap_en,
  input  logic                      dp_ap_r_nw,
  input  logic [1:0]                dp_ap_addr,
  input  logic [31:0]               dp_ap_wdata,
  input  logic [W_APSEL-1:0]        dp_select_apsel,
  input  logic [W_BANK-1:0]         dp_select_apbanksel,
  input  logic                      dp_abort,
  output logic [31:0]               dp_rdbuff,
  output logic                      ap_rdy,
  output logic                      dp_set_stickyerr,
  output logic                      ap_req,
  output logic [W_APSEL+W_BANK+3:0] ap_addr,
  output logic                      ap_wen,
  output logic [31:0]               ap_wdata,
  input  logic                      ap_ack,
  input  logic                      ap_err,
  input  logic [31:0]               ap_rdata,
  output logic                      ap_abort
);
  localparam int CW = W_TIMEOUT > 0 ? W_TIMEOUT : 1;
  sched_state_e r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic w_busy, w_start, w_done, w_abort, w_tmo;
  assign w_busy = r_state == SCHED_BUSY;
  assign w_start = !w_busy && dp_ap_en;
  assign w_done = w_busy && ap_ack;
  // ack wins over abort, abort wins over timeout
  assign w_abort = w_busy && !ap_ack && dp_abort;
  assign w_tmo = w_busy && !ap_ack && !dp_abort && (W_TIMEOUT > 0) && (&r_cnt);
  always_ff @(posedge swclk or negedge rst_n)
    if (!rst_n) r_state <= SCHED_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = w_start ? SCHED_BUSY : (w_done || w_abort || w_tmo) ? SCHED_IDLE : r_state;
  always_comb begin
    ap_rdy = !w_busy;
    ap_req = w_busy;
  end
  always_ff @(posedge swclk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      ap_addr <= '0;
      ap_wen <= 1'b0;
      ap_wdata <= '0;
      dp_rdbuff <= '0;
      dp_set_stickyerr <= 1'b0;
      ap_abort <= 1'b0;
    end else begin
      r_cnt <= ((W_TIMEOUT > 0) && w_busy && !ap_ack) ? r_cnt + 1'b1 : '0;
      dp_set_stickyerr <= (w_done && ap_err) || w_tmo;
      ap_abort <= w_abort || w_tmo;
      if (w_start) begin
        ap_addr <= {dp_select_apsel, dp_select_apbanksel, dp_ap_addr, 2'b00};
        ap_wen <= !dp_ap_r_nw;
        ap_wdata <= dp_ap_wdata;
      end
      if (w_done && !ap_wen && !ap_err) dp_rdbuff <= ap_rdata;
    end
endmodule

// File: tb/tb_opendap_ap_access_scheduler.sv
// tb_opendap_ap_access_scheduler: directed vector table, timeout/reset sequences and
// randomized traffic against a transaction-level reference model.
module tb_opendap_ap_access_scheduler;
  localparam int TW = 4;
  logic swclk = 1'b0, rst_n = 1'b0;
  logic dp_ap_en = 1'b0, dp_ap_r_nw = 1'b0, dp_abort = 1'b0;
  logic [1:0] dp_ap_addr = '0;
  logic [31:0] dp_ap_wdata = '0, ap_rdata = '0;
  logic [7:0] dp_select_apsel = '0;
  logic [3:0] dp_select_apbanksel = '0;
  logic ap_ack = 1'b0, ap_err = 1'b0;
  logic [31:0] dp_rdbuff, ap_wdata;
  logic ap_rdy, dp_set_stickyerr, ap_req, ap_wen, ap_abort;
  logic [15:0] ap_addr;
  int n_vec = 0, n_bad = 0;

  opendap_ap_access_scheduler #(.W_APSEL(8), .W_BANK(4), .W_TIMEOUT(TW)) dut (
    .swclk(swclk), .rst_n(rst_n), .dp_ap_en(dp_ap_en), .dp_ap_r_nw(dp_ap_r_nw),
    .dp_ap_addr(dp_ap_addr), .dp_ap_wdata(dp_ap_wdata), .dp_select_apsel(dp_select_apsel),
    .dp_select_apbanksel(dp_select_apbanksel), .dp_abort(dp_abort), .dp_rdbuff(dp_rdbuff),
    .ap_rdy(ap_rdy), .dp_set_stickyerr(dp_set_stickyerr), .ap_req(ap_req), .ap_addr(ap_addr),
    .ap_wen(ap_wen), .ap_wdata(ap_wdata), .ap_ack(ap_ack), .ap_err(ap_err),
    .ap_rdata(ap_rdata), .ap_abort(ap_abort)
  );

  always #5 swclk = ~swclk;

  // the DP never strobes an access while the scheduler is busy
  assert property (@(posedge swclk) disable iff (!rst_n) !(dp_ap_en && !ap_rdy));

  typedef struct {
    logic en, rnw;
    logic [1:0] a;
    logic [31:0] wd;
    logic [7:0] sel;
    logic [3:0] bank;
    logic abt, ack, err;
    logic [31:0] rd;
    logic rdy, req, st, ab;
    logic [31:0] rb;
    logic [15:0] addr;
    logic wen;
  } vec_t;
  vec_t tbl[22];

  bit m_busy, m_wen;
  int m_age;
  logic [31:0] m_rdbuff, m_wdata;
  logic [15:0] m_addr;
  logic e_st, e_ab;

  task automatic tick();
    @(posedge swclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dp_ap_en = 1'b0; dp_abort = 1'b0; ap_ack = 1'b0; ap_err = 1'b0;
  endtask

  // transaction-level view: one pending access with an age, resolved by ack, abort or age limit
  task automatic model_step();
    e_st = 1'b0;
    e_ab = 1'b0;
    if (!m_busy) begin
      if (dp_ap_en) begin
        m_busy = 1; m_age = 0; m_wen = !dp_ap_r_nw; m_wdata = dp_ap_wdata;
        m_addr = {dp_select_apsel, dp_select_apbanksel, dp_ap_addr, 2'b00};
      end
    end else if (ap_ack) begin
      m_busy = 0;
      if (ap_err) e_st = 1'b1;
      else if (!m_wen) m_rdbuff = ap_rdata;
    end else if (dp_abort) begin
      m_busy = 0; e_ab = 1'b1;
    end else if (m_age == (1 << TW) - 1) begin
      m_busy = 0; e_ab = 1'b1; e_st = 1'b1;
    end else m_age++;
  endtask

  initial begin
    tbl[0]  = '{1'b1,1'b0,2'd3,32'hDEADBEEF,8'h01,4'hF,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b0,32'h0,16'h01FC,1'b1};
    tbl[1]  = '{1'b0,1'b0,2'd0,32'h0,8'h01,4'hF,1'b0,1'b0,1'b0,32'h0,               1'b0,1'b1,1'b0,1'b0,32'h0,16'h01FC,1'b1};
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = '{1'b0,1'b0,2'd0,32'h0,8'h01,4'hF,1'b0,1'b1,1'b0,32'h0,               1'b1,1'b0,1'b0,1'b0,32'h0,16'h01FC,1'b1};
    tbl[5]  = '{1'b1,1'b1,2'd0,32'h0,8'h01,4'hF,1'b0,1'b0,1'b0,32'h0,               1'b0,1'b1,1'b0,1'b0,32'h0,16'h01F0,1'b0};
    tbl[6]  = '{1'b0,1'b0,2'd0,32'h0,8'h01,4'hF,1'b0,1'b1,1'b0,32'h12345678,        1'b1,1'b0,1'b0,1'b0,32'h12345678,16'h01F0,1'b0};
    tbl[7]  = '{1'b1,1'b1,2'd1,32'h0,8'h01,4'hF,1'b0,1'b0,1'b0,32'h0,               1'b0,1'b1,1'b0,1'b0,32'h12345678,16'h01F4,1'b0};
    tbl[8]  = '{1'b0,1'b0,2'd0,32'h0,8'h01,4'hF,1'b0,1'b1,1'b0,32'hCAFEF00D,        1'b1,1'b0,1'b0,1'b0,32'hCAFEF00D,16'h01F4,1'b0};
    tbl[9]  = '{1'b1,1'b1,2'd2,32'h0,8'h01,4'hF,1'b0,1'b0,1'b0,32'h0,               1'b0,1'b1,1'b0,1'b0,32'hCAFEF00D,16'h01F8,1'b0};
    tbl[10] = '{1'b0,1'b0,2'd0,32'h0,8'h01,4'hF,1'b0,1'b1,1'b1,32'hFFFFFFFF,        1'b1,1'b0,1'b1,1'b0,32'hCAFEF00D,16'h01F8,1'b0};
    tbl[11] = '{1'b0,1'b0,2'd0,32'h0,8'h01,4'hF,1'b0,1'b0,1'b0,32'h0,               1'b1,1'b0,1'b0,1'b0,32'hCAFEF00D,16'h01F8,1'b0};
    tbl[12] = '{1'b1,1'b0,2'd0,32'h0,8'h01,4'hF,1'b0,1'b0,1'b0,32'h0,               1'b0,1'b1,1'b0,1'b0,32'hCAFEF00D,16'h01F0,1'b1};
    tbl[13] = '{1'b0,1'b0,2'd0,32'h0,8'h01,4'hF,1'b1,1'b0,1'b0,32'h0,               1'b1,1'b0,1'b0,1'b1,32'hCAFEF00D,16'h01F0,1'b1};
    tbl[14] = '{1'b0,1'b0,2'd0,32'h0,8'h01,4'hF,1'b0,1'b0,1'b0,32'h0,               1'b1,1'b0,1'b0,1'b0,32'hCAFEF00D,16'h01F0,1'b1};
    tbl[15] = '{1'b1,1'b1,2'd1,32'h0,8'h01,4'hF,1'b0,1'b0,1'b0,32'h0,               1'b0,1'b1,1'b0,1'b0,32'hCAFEF00D,16'h01F4,1'b0};
    tbl[16] = '{1'b0,1'b0,2'd0,32'h0,8'h01,4'hF,1'b1,1'b1,1'b0,32'h0BADCAFE,        1'b1,1'b0,1'b0,1'b0,32'h0BADCAFE,16'h01F4,1'b0};
    tbl[17] = '{1'b0,1'b0,2'd0,32'h0,8'h01,4'hF,1'b1,1'b0,1'b0,32'h0,               1'b1,1'b0,1'b0,1'b0,32'h0BADCAFE,16'h01F4,1'b0};
    tbl[18] = '{1'b0,1'b0,2'd0,32'h0,8'h01,4'hF,1'b0,1'b1,1'b0,32'h11111111,        1'b1,1'b0,1'b0,1'b0,32'h0BADCAFE,16'h01F4,1'b0};
    tbl[19] = '{1'b1,1'b1,2'd2,32'h0,8'hA5,4'h3,1'b0,1'b0,1'b0,32'h0,               1'b0,1'b1,1'b0,1'b0,32'h0BADCAFE,16'hA538,1'b0};
    tbl[20] = '{1'b0,1'b0,2'd0,32'h0,8'h00,4'h0,1'b0,1'b0,1'b0,32'h0,               1'b0,1'b1,1'b0,1'b0,32'h0BADCAFE,16'hA538,1'b0};
    tbl[21] = '{1'b0,1'b0,2'd0,32'h0,8'h00,4'h0,1'b0,1'b1,1'b0,32'h5A5A5A5A,        1'b1,1'b0,1'b0,1'b0,32'h5A5A5A5A,16'hA538,1'b0};

    #2;
    chk("reset_rdy", ap_rdy, 1);
    chk("reset_req", ap_req, 0);
    chk("reset_addr", ap_addr, 0);
    chk("reset_wen", ap_wen, 0);
    chk("reset_wdata", ap_wdata, 0);
    chk("reset_rdbuff", dp_rdbuff, 0);
    chk("reset_sticky", dp_set_stickyerr, 0);
    chk("reset_abort", ap_abort, 0);
    @(negedge swclk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      dp_ap_en = tbl[i].en; dp_ap_r_nw = tbl[i].rnw; dp_ap_addr = tbl[i].a;
      dp_ap_wdata = tbl[i].wd; dp_select_apsel = tbl[i].sel; dp_select_apbanksel = tbl[i].bank;
      dp_abort = tbl[i].abt; ap_ack = tbl[i].ack; ap_err = tbl[i].err; ap_rdata = tbl[i].rd;
      tick();
      chk($sformatf("vec%0d_rdy", i), ap_rdy, tbl[i].rdy);
      chk($sformatf("vec%0d_req", i), ap_req, tbl[i].req);
      chk($sformatf("vec%0d_sticky", i), dp_set_stickyerr, tbl[i].st);
      chk($sformatf("vec%0d_abort", i), ap_abort, tbl[i].ab);
      chk($sformatf("vec%0d_rdbuff", i), dp_rdbuff, tbl[i].rb);
      chk($sformatf("vec%0d_addr", i), ap_addr, tbl[i].addr);
      chk($sformatf("vec%0d_wen", i), ap_wen, tbl[i].wen);
    end
    chk("vec0_wdata_held", ap_wdata, 32'h0);

    // unanswered read: counter walks 0..15 while busy, then timeout fires
    idle_inputs();
    dp_ap_en = 1'b1; dp_ap_r_nw = 1'b1; dp_ap_addr = 2'd0;
    dp_select_apsel = 8'h01; dp_select_apbanksel = 4'hF;
    tick();
    idle_inputs();
    chk("tmo_start_rdy", ap_rdy, 0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("tmo_wait%0d_rdy", i), ap_rdy, 0);
      chk($sformatf("tmo_wait%0d_abort", i), ap_abort, 0);
    end
    tick();
    chk("tmo_abort", ap_abort, 1);
    chk("tmo_sticky", dp_set_stickyerr, 1);
    chk("tmo_rdy", ap_rdy, 1);
    chk("tmo_req", ap_req, 0);
    chk("tmo_rdbuff", dp_rdbuff, 32'h5A5A5A5A);
    tick();
    chk("tmo_abort_pulse", ap_abort, 0);
    chk("tmo_sticky_pulse", dp_set_stickyerr, 0);
    dp_ap_en = 1'b1; dp_ap_r_nw = 1'b0; dp_ap_addr = 2'd1; dp_ap_wdata = 32'h600DF00D;
    tick();
    idle_inputs();
    chk("post_tmo_req", ap_req, 1);
    chk("post_tmo_addr", ap_addr, 16'h01F4);
    chk("post_tmo_wdata", ap_wdata, 32'h600DF00D);
    ap_ack = 1'b1;
    tick();
    ap_ack = 1'b0;
    chk("post_tmo_rdy", ap_rdy, 1);
    chk("post_tmo_sticky", dp_set_stickyerr, 0);

    // asynchronous reset while a request is outstanding
    dp_ap_en = 1'b1; dp_ap_r_nw = 1'b1;
    tick();
    idle_inputs();
    chk("rstmid_req_before", ap_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_req", ap_req, 0);
    chk("rstmid_rdy", ap_rdy, 1);
    chk("rstmid_rdbuff", dp_rdbuff, 0);
    chk("rstmid_abort", ap_abort, 0);
    @(negedge swclk);
    rst_n = 1'b1;

    m_busy = 0; m_wen = 0; m_age = 0; m_rdbuff = '0; m_wdata = '0; m_addr = '0;
    for (int i = 0; i < 1500; i++) begin
      dp_ap_en = !m_busy && ($urandom_range(0, 2) == 0);
      dp_ap_r_nw = 1'($urandom);
      dp_ap_addr = 2'($urandom);
      dp_ap_wdata = $urandom;
      dp_select_apsel = 8'($urandom);
      dp_select_apbanksel = 4'($urandom);
      dp_abort = $urandom_range(0, 11) == 0;
      ap_ack = $urandom_range(0, 6) == 0;
      ap_err = $urandom_range(0, 3) == 0;
      ap_rdata = $urandom;
      model_step();
      tick();
      chk($sformatf("rnd%0d_rdy", i), ap_rdy, !m_busy);
      chk($sformatf("rnd%0d_req", i), ap_req, m_busy);
      chk($sformatf("rnd%0d_sticky", i), dp_set_stickyerr, e_st);
      chk($sformatf("rnd%0d_abort", i), ap_abort, e_ab);
      chk($sformatf("rnd%0d_rdbuff", i), dp_rdbuff, m_rdbuff);
      chk($sformatf("rnd%0d_addr", i), ap_addr, m_addr);
      chk($sformatf("rnd%0d_wen", i), ap_wen, m_wen);
      chk($sformatf("rnd%0d_wdata", i), ap_wdata, m_wdata);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
